// File: rtl/prio_mixer_pkg.sv
// prio_mixer_pkg: shared definitions for the N-layer priority mixer.
//   - register offsets of the CPU register map
//   - blend mode encoding
//   - packed register-file image exported by the register block
//   - blend(): colour merge of the two winning layers
package prio_mixer_pkg;

   // Upper bound on the layer count; the register image is sized for it.
   localparam int MAX_LAYERS    = 8;

   localparam int REG_GLOBAL    = 0;
   localparam int REG_PRIO_BASE = 1;

   // Per-layer config registers follow the 2*N priority table bytes.
   function automatic int REG_LAYER_BASE(input int n);
      return 1 + 2 * n;
   endfunction

   typedef enum logic [1:0] {
      BLEND_NONE  = 2'd0,
      BLEND_RSVD  = 2'd1,
      BLEND_CLEAR = 2'd2,
      BLEND_MERGE = 2'd3
   } blend_mode_t;

   // Full register image. Entries for layers >= NUM_LAYERS stay zero.
   typedef struct packed {
      logic [MAX_LAYERS-1:0][7:0]  layer_cfg;   // [7] enable, [1:0] blend select
      logic [MAX_LAYERS-1:0][15:0] prio_table;  // four 4-bit priorities
      logic [7:0]                  global_cfg;  // [7:6] blend mode, [0] commit mode
   } mixer_cfg_t;

   // Combine the top colour (hi) with the second colour (lo). Operates on
   // 12-bit values; narrower palettes are zero-extended by the caller.
   function automatic logic [11:0] blend(input blend_mode_t mode,
                                         input logic [1:0]  h,
                                         input logic [11:0] hi,
                                         input logic [11:0] lo);
      logic [11:0] r;
      r = hi;
      if (mode == BLEND_MERGE) begin
         case (h)
            2'd0:    r = {lo[11:4], hi[3:0]};
            2'd1:    r = {lo[11:5], hi[4:0]};
            2'd2:    r = {lo[11:6], hi[5], lo[4], hi[3:0]};
            default: r = {lo[11:6], hi[5:0]};
         endcase
      end else if (mode == BLEND_CLEAR) begin
         case (h)
            2'd0:        r[4] = 1'b0;
            2'd1, 2'd2:  r[5] = 1'b0;
            default:     r[6] = 1'b0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_mixer_regs.sv
// prio_mixer_regs: CPU register file with pending and active copies.
//   clk, reset_n        clock, async active-low reset
//   vblank              vertical blank level (commit trigger in vblank mode)
//   cs/cpu_addr/cpu_rw/cpu_ds_n/cpu_din   CPU bus
//   cpu_dout            registered read data (pending copy)
//   active              active register image used by the pixel pipeline
module prio_mixer_regs
   import prio_mixer_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vblank,
   input  logic              cs,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rw,
   input  logic              cpu_ds_n,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output mixer_cfg_t        active
);

   mixer_cfg_t  pending_reg;
   mixer_cfg_t  pending_next;
   mixer_cfg_t  active_reg;
   logic        vblank_d_reg;
   logic [7:0]  cpu_dout_reg;
   logic [7:0]  rd_data;
   logic [31:0] addr_ext;
   logic        wr_en;
   logic        rd_en;
   logic        commit;

   assign addr_ext = 32'(cpu_addr);
   assign wr_en    = cs & ~cpu_rw & ~cpu_ds_n;
   assign rd_en    = cs & cpu_rw;

   // Commit mode is always read from the pending copy so the CPU can leave
   // vblank mode without waiting for a vblank.
   assign commit = ~pending_reg.global_cfg[0] | (vblank & ~vblank_d_reg);

   always_comb begin
      pending_next = pending_reg;
      rd_data      = 8'd0;
      if (addr_ext == 32'(REG_GLOBAL)) begin
         pending_next.global_cfg = cpu_din;
         rd_data                 = pending_reg.global_cfg;
      end
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (addr_ext == 32'(REG_PRIO_BASE + 2 * i)) begin
            pending_next.prio_table[i][7:0] = cpu_din;
            rd_data = pending_reg.prio_table[i][7:0];
         end
         if (addr_ext == 32'(REG_PRIO_BASE + 2 * i + 1)) begin
            pending_next.prio_table[i][15:8] = cpu_din;
            rd_data = pending_reg.prio_table[i][15:8];
         end
         if (addr_ext == 32'(REG_LAYER_BASE(NUM_LAYERS) + i)) begin
            pending_next.layer_cfg[i] = cpu_din;
            rd_data = pending_reg.layer_cfg[i];
         end
      end
   end

   // A commit and a write on the same edge: the commit copies the pre-write
   // pending value because both use the register contents before the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_reg  <= '0;
         active_reg   <= '0;
         vblank_d_reg <= 1'b0;
         cpu_dout_reg <= 8'd0;
      end else begin
         vblank_d_reg <= vblank;
         if (commit)
            active_reg <= pending_reg;
         if (wr_en)
            pending_reg <= pending_next;
         if (rd_en)
            cpu_dout_reg <= rd_data;
      end
   end

   assign active   = active_reg;
   assign cpu_dout = cpu_dout_reg;

endmodule

// File: rtl/prio_mixer.sv
// prio_mixer: N-layer priority mixer with adjacent-priority blending.
//   clk, reset_n        clock, async active-low reset
//   ce_pixel            pixel enable; all three stages advance together
//   vblank              vertical blank level
//   cs/cpu_addr/cpu_rw/cpu_ds_n/cpu_din/cpu_dout   CPU register port
//   color_in            per layer {priority select[1:0], palette index}
//   color_out           mixed palette index (3 enabled pixels latency)
//   out_layer           winning layer index
module prio_mixer
   import prio_mixer_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int COLOR_W    = 12,
   parameter int ADDR_W     = 5
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               ce_pixel,
   input  logic                               vblank,
   input  logic                               cs,
   input  logic [ADDR_W-1:0]                  cpu_addr,
   input  logic                               cpu_rw,
   input  logic                               cpu_ds_n,
   input  logic [7:0]                         cpu_din,
   output logic [7:0]                         cpu_dout,
   input  logic [NUM_LAYERS*(2+COLOR_W)-1:0]  color_in,
   output logic [COLOR_W-1:0]                 color_out,
   output logic [2:0]                         out_layer
);

   localparam int LW = 2 + COLOR_W;

   mixer_cfg_t active;
   logic       unused_cfg;

   prio_mixer_regs #(.NUM_LAYERS(NUM_LAYERS), .ADDR_W(ADDR_W)) u_regs (
      .clk      (clk),
      .reset_n  (reset_n),
      .vblank   (vblank),
      .cs       (cs),
      .cpu_addr (cpu_addr),
      .cpu_rw   (cpu_rw),
      .cpu_ds_n (cpu_ds_n),
      .cpu_din  (cpu_din),
      .cpu_dout (cpu_dout),
      .active   (active)
   );

   // Not every register bit drives the pipeline (reserved bits, unused layers).
   assign unused_cfg = ^active;

   // ---------------- S1: priority lookup ----------------
   logic [NUM_LAYERS-1:0][3:0]          pri_next;
   logic [NUM_LAYERS-1:0][COLOR_W-1:0]  s1_color_reg;
   logic [NUM_LAYERS-1:0][3:0]          s1_pri_reg;
   logic [NUM_LAYERS-1:0][1:0]          s1_hsel_reg;
   blend_mode_t                         s1_mode_reg;

   always_comb begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
         pri_next[i] = 4'd0;
         // Index nibble 0 is the transparent pen in every palette bank.
         if (active.layer_cfg[i][7] && color_in[i*LW +: 4] != 4'd0)
            pri_next[i] = active.prio_table[i][{color_in[i*LW+COLOR_W +: 2], 2'b00} +: 4];
      end
   end

   // ---------------- S2: top / second selection ----------------
   logic [3:0]         top_pri;
   logic [2:0]         top_idx;
   logic [COLOR_W-1:0] top_color;
   logic [1:0]         top_hsel;
   logic               sec_valid;
   logic [COLOR_W-1:0] sec_color;

   always_comb begin
      top_pri   = 4'd0;
      top_idx   = 3'd0;
      top_color = '0;
      top_hsel  = 2'd0;
      // Strict compare keeps the lowest index on ties.
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (s1_pri_reg[i] > top_pri) begin
            top_pri   = s1_pri_reg[i];
            top_idx   = 3'(i);
            top_color = s1_color_reg[i];
            top_hsel  = s1_hsel_reg[i];
         end
      end
      sec_valid = 1'b0;
      sec_color = '0;
      // A priority-0 layer is transparent and never blends.
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (!sec_valid && top_pri > 4'd1 && 3'(i) != top_idx &&
             s1_pri_reg[i] == top_pri - 4'd1) begin
            sec_valid = 1'b1;
            sec_color = s1_color_reg[i];
         end
      end
   end

   logic [COLOR_W-1:0] s2_top_color_reg;
   logic [COLOR_W-1:0] s2_sec_color_reg;
   logic               s2_sec_valid_reg;
   logic [1:0]         s2_hsel_reg;
   blend_mode_t        s2_mode_reg;
   logic [2:0]         s2_layer_reg;

   // ---------------- S3: blend ----------------
   logic [COLOR_W-1:0] mixed;
   logic [COLOR_W-1:0] color_out_reg;
   logic [2:0]         out_layer_reg;

   always_comb begin
      mixed = s2_top_color_reg;
      if (s2_sec_valid_reg)
         mixed = COLOR_W'(blend(s2_mode_reg, s2_hsel_reg,
                                12'(s2_top_color_reg), 12'(s2_sec_color_reg)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_color_reg     <= '0;
         s1_pri_reg       <= '0;
         s1_hsel_reg      <= '0;
         s1_mode_reg      <= BLEND_NONE;
         s2_top_color_reg <= '0;
         s2_sec_color_reg <= '0;
         s2_sec_valid_reg <= 1'b0;
         s2_hsel_reg      <= 2'd0;
         s2_mode_reg      <= BLEND_NONE;
         s2_layer_reg     <= 3'd0;
         color_out_reg    <= '0;
         out_layer_reg    <= 3'd0;
      end else if (ce_pixel) begin
         // Blend controls travel with the pixel so a commit never splits one.
         for (int i = 0; i < NUM_LAYERS; i++) begin
            s1_color_reg[i] <= color_in[i*LW +: COLOR_W];
            s1_hsel_reg[i]  <= active.layer_cfg[i][1:0];
         end
         s1_pri_reg       <= pri_next;
         s1_mode_reg      <= blend_mode_t'(active.global_cfg[7:6]);
         s2_top_color_reg <= top_color;
         s2_sec_color_reg <= sec_color;
         s2_sec_valid_reg <= sec_valid;
         s2_hsel_reg      <= top_hsel;
         s2_mode_reg      <= s1_mode_reg;
         s2_layer_reg     <= top_idx;
         color_out_reg    <= mixed;
         out_layer_reg    <= s2_layer_reg;
      end
   end

   assign color_out = color_out_reg;
   assign out_layer = out_layer_reg;

endmodule

// File: tb/tb_prio_mixer.sv
module tb_prio_mixer;

   localparam int N  = 4;
   localparam int CW = 12;
   localparam int AW = 5;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            ce_pixel;
   logic            vblank;
   logic            cs;
   logic [AW-1:0]   cpu_addr;
   logic            cpu_rw;
   logic            cpu_ds_n;
   logic [7:0]      cpu_din;
   logic [7:0]      cpu_dout;
   logic [N*(2+CW)-1:0] color_in;
   logic [CW-1:0]   color_out;
   logic [2:0]      out_layer;

   always #5 clk = ~clk;

   prio_mixer #(.NUM_LAYERS(N), .COLOR_W(CW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce_pixel  (ce_pixel),
      .vblank    (vblank),
      .cs        (cs),
      .cpu_addr  (cpu_addr),
      .cpu_rw    (cpu_rw),
      .cpu_ds_n  (cpu_ds_n),
      .cpu_din   (cpu_din),
      .cpu_dout  (cpu_dout),
      .color_in  (color_in),
      .color_out (color_out),
      .out_layer (out_layer)
   );

   typedef struct {
      logic [11:0] c;
      logic [2:0]  l;
   } pix_t;

   pix_t       exp_q[$];
   logic [7:0] rd_q[$];
   pix_t       mon_e;
   logic [7:0] mon_r;
   int         n_checks = 0;
   int         n_pass   = 0;

   logic       pix_tag;
   logic [2:0] vp;
   logic       out_new;
   logic       rd_new;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("ok   %s: %0h", name, act);
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Track which enabled pixel slots carry a scoreboard entry.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vp      <= 3'd0;
         out_new <= 1'b0;
         rd_new  <= 1'b0;
      end else begin
         out_new <= ce_pixel & vp[1];
         if (ce_pixel)
            vp <= {vp[1:0], pix_tag};
         rd_new <= cs & cpu_rw;
      end
   end

   // Monitor: compare on the falling edge whenever a new output appears.
   always @(negedge clk) begin
      if (out_new) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pixel_underflow: got output %0h, expected none", color_out);
         end else begin
            mon_e = exp_q.pop_front();
            check("pixel_color", 32'(color_out), 32'(mon_e.c));
            check("pixel_layer", 32'(out_layer), 32'(mon_e.l));
         end
      end
      if (rd_new) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL read_underflow: got %0h, expected none", cpu_dout);
         end else begin
            mon_r = rd_q.pop_front();
            check("cpu_read", 32'(cpu_dout), 32'(mon_r));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input int a, input logic [7:0] d);
      cs       = 1'b1;
      cpu_rw   = 1'b0;
      cpu_ds_n = 1'b0;
      cpu_addr = AW'(a);
      cpu_din  = d;
      tick();
      cs       = 1'b0;
      cpu_ds_n = 1'b1;
      cpu_rw   = 1'b1;
   endtask

   task automatic cpu_read(input int a, input logic [7:0] e);
      cs       = 1'b1;
      cpu_rw   = 1'b1;
      cpu_addr = AW'(a);
      rd_q.push_back(e);
      tick();
      cs       = 1'b0;
   endtask

   task automatic set_table(input int layer, input logic [15:0] v);
      cpu_write(1 + 2 * layer, v[7:0]);
      cpu_write(2 + 2 * layer, v[15:8]);
   endtask

   task automatic pixel(input logic [11:0] c0, input logic [1:0] s0,
                        input logic [11:0] c1, input logic [1:0] s1,
                        input logic [11:0] c2, input logic [1:0] s2,
                        input logic [11:0] c3, input logic [1:0] s3,
                        input logic [11:0] ec, input logic [2:0] el);
      pix_t e;
      e.c = ec;
      e.l = el;
      exp_q.push_back(e);
      color_in = {s3, c3, s2, c2, s1, c1, s0, c0};
      pix_tag  = 1'b1;
      ce_pixel = 1'b1;
      tick();
      ce_pixel = 1'b0;
   endtask

   // Push in-flight pixels out with untracked blank pixels.
   task automatic drain;
      color_in = '0;
      pix_tag  = 1'b0;
      ce_pixel = 1'b1;
      repeat (3) tick();
      ce_pixel = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b0;
      ce_pixel = 1'b0;
      vblank   = 1'b0;
      cs       = 1'b0;
      cpu_addr = '0;
      cpu_rw   = 1'b1;
      cpu_ds_n = 1'b1;
      cpu_din  = 8'd0;
      color_in = '0;
      pix_tag  = 1'b0;
      #2;
      check("reset_color_out", 32'(color_out), 32'h0);
      check("reset_out_layer", 32'(out_layer), 32'h0);
      check("reset_cpu_dout",  32'(cpu_dout),  32'h0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      // Immediate mode: all tables 0x4321, all layers enabled, no blending.
      for (int i = 0; i < N; i++) set_table(i, 16'h4321);
      for (int i = 0; i < N; i++) cpu_write(9 + i, 8'h80);
      tick();

      pixel(12'h110, 2'd0, 12'h220, 2'd0, 12'h0A5, 2'd0, 12'h330, 2'd0, 12'h0A5, 3'd2);
      pixel(12'h011, 2'd1, 12'h022, 2'd3, 12'h033, 2'd2, 12'h044, 2'd3, 12'h022, 3'd1);
      pixel(12'h100, 2'd0, 12'h200, 2'd1, 12'h300, 2'd2, 12'h400, 2'd3, 12'h000, 3'd0);
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h000, 2'd0, 12'h045, 2'd1, 12'h045, 3'd3);

      // Pixel enable low: output must hold the last shown pixel.
      repeat (5) tick();
      check("hold_color_out", 32'(color_out), 32'h022);
      check("hold_out_layer", 32'(out_layer), 32'h1);

      // Merge blend: top L1 prio 5 sel 1 over L0 prio 4.
      set_table(1, 16'h0005);
      set_table(0, 16'h0054);
      cpu_write(10, 8'h81);
      cpu_write(0, 8'hC0);
      tick();
      pixel(12'hABC, 2'd0, 12'h123, 2'd0, 12'h000, 2'd0, 12'h000, 2'd0, 12'hAA3, 3'd1);

      // Clear blend with select 3, then same top without a second layer.
      cpu_write(0, 8'h80);
      cpu_write(10, 8'h83);
      tick();
      pixel(12'hABC, 2'd0, 12'h07F, 2'd0, 12'h000, 2'd0, 12'h000, 2'd0, 12'h03F, 3'd1);
      pixel(12'h000, 2'd0, 12'h07F, 2'd0, 12'h000, 2'd0, 12'h000, 2'd0, 12'h07F, 3'd1);

      // Vblank commit mode.
      cpu_write(10, 8'h80);
      cpu_write(0, 8'h00);
      tick();
      cpu_write(0, 8'h01);
      tick();
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h0A5, 3'd2);
      cpu_write(7, 8'h29);
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h0A5, 3'd2);
      vblank = 1'b1;
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h0A5, 3'd2);
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h036, 3'd3);
      vblank = 1'b0;
      tick();

      // Write on the commit edge lands one frame later.
      vblank   = 1'b1;
      cs       = 1'b1;
      cpu_rw   = 1'b0;
      cpu_ds_n = 1'b0;
      cpu_addr = AW'(5);
      cpu_din  = 8'h2A;
      tick();
      cs       = 1'b0;
      cpu_ds_n = 1'b1;
      cpu_rw   = 1'b1;
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h036, 3'd3);
      vblank = 1'b0;
      tick();
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h0A5, 3'd2);
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h0A5, 3'd2);
      pixel(12'h000, 2'd0, 12'h000, 2'd0, 12'h0A5, 2'd0, 12'h036, 2'd0, 12'h0A5, 3'd2);

      // Read back the pending copy and two unmapped addresses.
      cpu_read(0, 8'h01);
      cpu_read(1, 8'h54);
      cpu_read(2, 8'h00);
      cpu_read(3, 8'h05);
      cpu_read(4, 8'h00);
      cpu_read(5, 8'h2A);
      cpu_read(6, 8'h43);
      cpu_read(7, 8'h29);
      cpu_read(8, 8'h43);
      cpu_read(10, 8'h80);
      cpu_read(11, 8'h80);
      cpu_read(12, 8'h80);
      cpu_read(13, 8'h00);
      cpu_read(31, 8'h00);
      cpu_read(9, 8'h80);

      // Asynchronous reset mid-frame.
      @(posedge clk);
      #3;
      check("pre_reset_color_out", 32'(color_out), 32'h0A5);
      reset_n = 1'b0;
      #1;
      check("async_reset_color_out", 32'(color_out), 32'h0);
      check("async_reset_out_layer", 32'(out_layer), 32'h0);
      check("async_reset_cpu_dout",  32'(cpu_dout),  32'h0);
      exp_q.delete();
      rd_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      for (int a = 0; a < 13; a++) cpu_read(a, 8'h00);
      cpu_read(31, 8'h00);

      // After reset every layer is disabled: visible-looking pixels are transparent.
      pixel(12'h0A5, 2'd0, 12'h123, 2'd1, 12'h456, 2'd2, 12'h789, 2'd3, 12'h000, 3'd0);
      drain();
      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("read_queue_drained", 32'(rd_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
